// File: rtl/tx_msg_streamer_pkg.sv
// Shared types and constants for the message streamer: FSM encoding and ASCII trailer bytes.
package tx_msg_streamer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StSend,
        StCr,
        StLf,
        StFin
    } state_e;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

endpackage

// File: rtl/tx_msg_ram.sv
// Message storage: one synchronous write port and one registered read port.
module tx_msg_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 7
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/tx_msg_streamer.sv
// Streams a stored message byte-by-byte over a valid/ready handshake, with optional CR/LF
// trailer, repeat and abort.
module tx_msg_streamer
    import tx_msg_streamer_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned MAX_LEN     = 32,
    parameter int unsigned NUM_MSG     = 4,
    parameter bit          APPEND_CRLF = 1'b1,
    localparam int unsigned AW         = $clog2(MAX_LEN),
    localparam int unsigned SW         = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iWR_EN,
    input  logic [SW-1:0]     iWR_MSG,
    input  logic [AW-1:0]     iWR_ADDR,
    input  logic [DATA_W-1:0] iWR_DATA,
    input  logic              iLEN_WE,
    input  logic [SW-1:0]     iLEN_MSG,
    input  logic [AW:0]       iLEN,
    input  logic              iSTART,
    input  logic [SW-1:0]     iMSG_SEL,
    input  logic              iREPEAT,
    input  logic              iABORT,
    output logic [DATA_W-1:0] oTX_DATA,
    output logic              oTX_VALID,
    input  logic              iTX_READY,
    output logic              oBUSY,
    output logic              oDONE
);

    localparam int unsigned LW = AW + 1;

    state_e            state_q, state_d;
    logic [AW:0]       len_q [NUM_MSG];
    logic [AW:0]       len_wr;
    logic [AW:0]       cur_len_q;
    logic [AW:0]       idx_q;
    logic [SW-1:0]     slot_q;
    logic              abort_q;
    logic              abort_any;
    logic              last_byte;
    logic [DATA_W-1:0] ram_rd_data;
    state_e            empty_next;

    tx_msg_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (SW + AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (iWR_EN),
        .wr_addr ({iWR_MSG, iWR_ADDR}),
        .wr_data (iWR_DATA),
        .rd_en   (state_q == StFetch),
        .rd_addr ({slot_q, idx_q[AW-1:0]}),
        .rd_data (ram_rd_data)
    );

    assign len_wr     = (iLEN > LW'(MAX_LEN)) ? LW'(MAX_LEN) : iLEN;
    assign abort_any  = iABORT | abort_q;
    // A length shrunk below the current index still ends the message on this byte.
    assign last_byte  = (idx_q + LW'(1)) >= cur_len_q;
    assign empty_next = APPEND_CRLF ? StCr : StFin;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!iABORT && iSTART) begin
                    state_d = (len_q[iMSG_SEL] == '0) ? empty_next : StFetch;
                end
            end
            StFetch: state_d = iABORT ? StIdle : StSend;
            StSend: begin
                if (iTX_READY) begin
                    if (abort_any)      state_d = StIdle;
                    else if (last_byte) state_d = empty_next;
                    else                state_d = StFetch;
                end
            end
            StCr: if (iTX_READY) state_d = abort_any ? StIdle : StLf;
            StLf: if (iTX_READY) state_d = abort_any ? StIdle : StFin;
            StFin: begin
                if (iABORT || !iREPEAT) state_d = StIdle;
                else state_d = (len_q[slot_q] == '0) ? empty_next : StFetch;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        oTX_VALID = 1'b0;
        oTX_DATA  = '0;
        unique case (state_q)
            StSend: begin
                oTX_VALID = 1'b1;
                oTX_DATA  = ram_rd_data;
            end
            StCr: begin
                oTX_VALID = 1'b1;
                oTX_DATA  = DATA_W'(CHAR_CR);
            end
            StLf: begin
                oTX_VALID = 1'b1;
                oTX_DATA  = DATA_W'(CHAR_LF);
            end
            default: ;
        endcase
        oBUSY = (state_q != StIdle);
        oDONE = (state_q == StFin);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q     <= '0;
            slot_q    <= '0;
            cur_len_q <= '0;
            abort_q   <= 1'b0;
        end else begin
            if (state_q == StIdle && iSTART) begin
                slot_q <= iMSG_SEL;
            end
            if (state_q == StIdle || state_q == StFin) begin
                idx_q <= '0;
            end else if (state_q == StSend && iTX_READY && state_d == StFetch) begin
                idx_q <= idx_q + LW'(1);
            end
            if (state_q == StFetch) begin
                cur_len_q <= len_q[slot_q];
            end
            if (state_q == StIdle) begin
                abort_q <= 1'b0;
            end else if (iABORT) begin
                abort_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_MSG; i++) begin
                len_q[i] <= '0;
            end
        end else if (iLEN_WE) begin
            len_q[iLEN_MSG] <= len_wr;
        end
    end

endmodule
